// File: rtl/snake_ir_pkg.sv
// Shared types and helpers for the IR direction scheduler: direction codes,
// NEC command bytes, scheduler FSM states and command/direction mapping.
package snake_ir_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_FILTER
    } sched_state_t;

    localparam logic [7:0] CMD_UP    = 8'h6A;
    localparam logic [7:0] CMD_DOWN  = 8'hEA;
    localparam logic [7:0] CMD_LEFT  = 8'h1A;
    localparam logic [7:0] CMD_RIGHT = 8'h9A;

    function automatic dir_t opposite(input dir_t d);
        dir_t r;
        r = DIR_DOWN;
        case (d)
            DIR_UP:    r = DIR_DOWN;
            DIR_DOWN:  r = DIR_UP;
            DIR_LEFT:  r = DIR_RIGHT;
            DIR_RIGHT: r = DIR_LEFT;
            default:   r = DIR_DOWN;
        endcase
        return r;
    endfunction

    function automatic logic nec_cmd_known(input logic [7:0] cmd);
        return (cmd == CMD_UP) || (cmd == CMD_DOWN) ||
               (cmd == CMD_LEFT) || (cmd == CMD_RIGHT);
    endfunction

    // Unknown commands map to DIR_UP; callers gate with nec_cmd_known.
    function automatic dir_t nec_cmd_to_dir(input logic [7:0] cmd);
        dir_t r;
        r = DIR_UP;
        case (cmd)
            CMD_DOWN:  r = DIR_DOWN;
            CMD_LEFT:  r = DIR_LEFT;
            CMD_RIGHT: r = DIR_RIGHT;
            default:   r = DIR_UP;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ir_dir_fifo.sv
// Small direction FIFO with extra-MSB pointers; head is read combinationally.
module ir_dir_fifo
    import snake_ir_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push_i,
    input  dir_t data_i,
    input  logic pop_i,
    output dir_t head_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wrPtr_q;
    logic [AW:0] rdPtr_q;
    dir_t        mem_q [DEPTH];
    logic        doPop;
    logic        doPush;

    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                     (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    // A full FIFO may still accept a push when the head leaves in the same cycle.
    assign doPop   = pop_i && !empty_o;
    assign doPush  = push_i && (!full_o || doPop);
    assign head_o  = mem_q[rdPtr_q[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + (AW+1)'(1);
            if (doPop)  rdPtr_q <= rdPtr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/ir_dir_scheduler.sv
// Validates NEC frames, filters illegal snake moves and queues the rest.
// Optional statistics counters are enabled by defining IR_DIR_STATS_EN.
module ir_dir_scheduler
    import snake_ir_pkg::*;
#(
    parameter int unsigned DEPTH          = 4,
    parameter logic [31:0] HOLDOFF_CYCLES = 32'd5_000_000,
    parameter logic [7:0]  NEC_ADDR       = 8'h20,
    parameter dir_t        RESET_DIR      = DIR_RIGHT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir_word,
    input  logic        ir_strobe,
    output dir_t        dir_out,
    output logic        dir_valid,
    input  logic        dir_ready,
    output logic        frame_err,
    output logic        overflow
`ifdef IR_DIR_STATS_EN
    ,
    output logic [15:0] stat_accept,
    output logic [15:0] stat_err,
    output logic [15:0] stat_drop
`endif
);

    sched_state_t state_q;
    logic [31:0]  word_q;
    dir_t         dir_q;
    dir_t         lastDir_q;
    logic [31:0]  holdCnt_q;
    logic [31:0]  holdCnt_d;
    logic         frameErr_q;
    logic         overflow_q;

    logic frameOk;
    logic legalMove;
    logic popFire;
    logic pushFire;
    logic overflowHit;
    logic fifoFull;
    logic fifoEmpty;
    dir_t fifoHead;

    assign frameOk = (word_q[31:24] == NEC_ADDR) &&
                     (word_q[23:16] == ~word_q[31:24]) &&
                     (word_q[7:0] == ~word_q[15:8]) &&
                     nec_cmd_known(word_q[15:8]);

    // Filtering against the last enqueued move lets queued moves chain legally.
    assign legalMove   = (dir_q != lastDir_q) && (dir_q != opposite(lastDir_q));
    assign popFire     = dir_ready && !fifoEmpty;
    assign pushFire    = (state_q == ST_FILTER) && legalMove && (!fifoFull || popFire);
    assign overflowHit = (state_q == ST_FILTER) && legalMove && fifoFull && !popFire;

    always_comb begin
        holdCnt_d = holdCnt_q;
        if (pushFire)
            holdCnt_d = HOLDOFF_CYCLES;
        else if (holdCnt_q != 32'd0)
            holdCnt_d = holdCnt_q - 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            word_q     <= '0;
            dir_q      <= RESET_DIR;
            lastDir_q  <= RESET_DIR;
            holdCnt_q  <= '0;
            frameErr_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            holdCnt_q  <= holdCnt_d;
            frameErr_q <= 1'b0;
            overflow_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ir_strobe && (holdCnt_q == 32'd0)) begin
                        word_q  <= ir_word;
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (frameOk) begin
                        dir_q   <= nec_cmd_to_dir(word_q[15:8]);
                        state_q <= ST_FILTER;
                    end else begin
                        frameErr_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                ST_FILTER: begin
                    if (pushFire) lastDir_q <= dir_q;
                    overflow_q <= overflowHit;
                    state_q    <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    ir_dir_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push_i (pushFire),
        .data_i (dir_q),
        .pop_i  (dir_ready),
        .head_o (fifoHead),
        .full_o (fifoFull),
        .empty_o(fifoEmpty)
    );

    assign dir_out   = fifoEmpty ? RESET_DIR : fifoHead;
    assign dir_valid = !fifoEmpty;
    assign frame_err = frameErr_q;
    assign overflow  = overflow_q;

`ifdef IR_DIR_STATS_EN
    logic [15:0] statAccept_q;
    logic [15:0] statErr_q;
    logic [15:0] statDrop_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            statAccept_q <= '0;
            statErr_q    <= '0;
            statDrop_q   <= '0;
        end else begin
            if (pushFire && (statAccept_q != 16'hFFFF))
                statAccept_q <= statAccept_q + 16'd1;
            if ((state_q == ST_CHECK) && !frameOk && (statErr_q != 16'hFFFF))
                statErr_q <= statErr_q + 16'd1;
            if ((state_q == ST_FILTER) && (!legalMove || overflowHit) && (statDrop_q != 16'hFFFF))
                statDrop_q <= statDrop_q + 16'd1;
        end
    end

    assign stat_accept = statAccept_q;
    assign stat_err    = statErr_q;
    assign stat_drop   = statDrop_q;
`endif

endmodule

// File: tb/tb_ir_dir_scheduler.sv
// Directed bench for ir_dir_scheduler: a scoreboard queue of expected moves
// for a zero-hold-off instance, plus a second instance exercising hold-off.
module tb_ir_dir_scheduler;
    import snake_ir_pkg::*;

    localparam int DEPTH_A = 4;
    localparam logic [31:0] W_UP    = 32'h20DF6A95;
    localparam logic [31:0] W_DOWN  = 32'h20DFEA15;
    localparam logic [31:0] W_LEFT  = 32'h20DF1AE5;
    localparam logic [31:0] W_RIGHT = 32'h20DF9A65;

    logic        clk;
    logic        reset;
    logic [31:0] irWord;
    logic        irStrobe;
    dir_t        dirOut;
    logic        dirValid;
    logic        dirReady;
    logic        frameErr;
    logic        overflow;

    logic [31:0] holdWord;
    logic        holdStrobe;
    dir_t        holdOut;
    logic        holdValid;
    logic        holdReady;
    logic        holdErr;
    logic        holdOvf;

`ifdef IR_DIR_STATS_EN
    logic [15:0] aAcc, aErr, aDrop, bAcc, bErr, bDrop;
`endif

    int   total = 0;
    int   bad   = 0;
    dir_t expQ[$];
    dir_t modelLast;

    ir_dir_scheduler #(
        .DEPTH(DEPTH_A), .HOLDOFF_CYCLES(32'd0), .NEC_ADDR(8'h20), .RESET_DIR(DIR_RIGHT)
    ) dut (
        .clk(clk), .reset(reset), .ir_word(irWord), .ir_strobe(irStrobe),
        .dir_out(dirOut), .dir_valid(dirValid), .dir_ready(dirReady),
        .frame_err(frameErr), .overflow(overflow)
`ifdef IR_DIR_STATS_EN
        , .stat_accept(aAcc), .stat_err(aErr), .stat_drop(aDrop)
`endif
    );

    ir_dir_scheduler #(
        .DEPTH(4), .HOLDOFF_CYCLES(32'd100), .NEC_ADDR(8'h20), .RESET_DIR(DIR_RIGHT)
    ) dutHold (
        .clk(clk), .reset(reset), .ir_word(holdWord), .ir_strobe(holdStrobe),
        .dir_out(holdOut), .dir_valid(holdValid), .dir_ready(holdReady),
        .frame_err(holdErr), .overflow(holdOvf)
`ifdef IR_DIR_STATS_EN
        , .stat_accept(bAcc), .stat_err(bErr), .stat_drop(bDrop)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: run did not finish observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic benchFrameOk(input logic [31:0] w);
        logic [7:0] c;
        c = w[15:8];
        return (w[31:24] == 8'h20) && (w[23:16] == 8'hDF) && (w[7:0] == ~c) &&
               ((c == 8'h6A) || (c == 8'hEA) || (c == 8'h1A) || (c == 8'h9A));
    endfunction

    function automatic dir_t benchDir(input logic [7:0] c);
        if (c == 8'h6A) return DIR_UP;
        if (c == 8'hEA) return DIR_DOWN;
        if (c == 8'h1A) return DIR_LEFT;
        return DIR_RIGHT;
    endfunction

    function automatic dir_t benchOpp(input dir_t d);
        if (d == DIR_UP)   return DIR_DOWN;
        if (d == DIR_DOWN) return DIR_UP;
        if (d == DIR_LEFT) return DIR_RIGHT;
        return DIR_LEFT;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Sends one frame to the zero-hold-off instance; the predicted move is
    // pushed to the scoreboard at drive time. popInFilter pops the head
    // during the FILTER cycle.
    task automatic applyStimulus(input string tag, input logic [31:0] w, input bit popInFilter);
        logic expErr;
        logic expOvf;
        dir_t d;
        int   sizeBefore;
        dir_t popExp;
        expErr     = !benchFrameOk(w);
        expOvf     = 1'b0;
        sizeBefore = expQ.size();
        popExp     = (sizeBefore != 0) ? expQ[0] : DIR_RIGHT;
        if (!expErr) begin
            d = benchDir(w[15:8]);
            if ((d != modelLast) && (d != benchOpp(modelLast))) begin
                if ((sizeBefore < DEPTH_A) || popInFilter) begin
                    expQ.push_back(d);
                    modelLast = d;
                end else begin
                    expOvf = 1'b1;
                end
            end
        end
        irWord   = w;
        irStrobe = 1'b1;
        tick();
        irStrobe = 1'b0;
        tick();
        checkOutput({tag, ".frameErr"}, 32'(frameErr), 32'(expErr));
        checkOutput({tag, ".validEarly"}, 32'(dirValid), 32'(sizeBefore != 0));
        if (popInFilter) begin
            checkOutput({tag, ".popHead"}, 32'(dirOut), 32'(popExp));
            dirReady = 1'b1;
        end
        tick();
        if (popInFilter) begin
            dirReady = 1'b0;
            void'(expQ.pop_front());
        end
        checkOutput({tag, ".overflow"}, 32'(overflow), 32'(expOvf));
        checkOutput({tag, ".errCleared"}, 32'(frameErr), 32'd0);
        checkOutput({tag, ".valid"}, 32'(dirValid), 32'(expQ.size() != 0));
        if (expQ.size() != 0)
            checkOutput({tag, ".head"}, 32'(dirOut), 32'(expQ[0]));
    endtask

    task automatic popAndCheck(input string tag);
        checkOutput({tag, ".validBefore"}, 32'(dirValid), 32'd1);
        checkOutput({tag, ".head"}, 32'(dirOut), 32'(expQ[0]));
        dirReady = 1'b1;
        tick();
        dirReady = 1'b0;
        void'(expQ.pop_front());
        checkOutput({tag, ".validAfter"}, 32'(dirValid), 32'(expQ.size() != 0));
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        expQ.delete();
        modelLast = DIR_RIGHT;
        tick();
    endtask

    initial begin
        int e;
        reset      = 1'b1;
        irWord     = '0;
        irStrobe   = 1'b0;
        dirReady   = 1'b0;
        holdWord   = '0;
        holdStrobe = 1'b0;
        holdReady  = 1'b0;
        modelLast  = DIR_RIGHT;
        tick();
        tick();
        checkOutput("rst.dirOut", 32'(dirOut), 32'(DIR_RIGHT));
        checkOutput("rst.valid", 32'(dirValid), 32'd0);
        checkOutput("rst.frameErr", 32'(frameErr), 32'd0);
        checkOutput("rst.overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        tick();

        applyStimulus("up1", W_UP, 1'b0);
        popAndCheck("pop1");
        dirReady = 1'b1;
        tick();
        dirReady = 1'b0;
        checkOutput("emptyPop.valid", 32'(dirValid), 32'd0);
        checkOutput("emptyPop.dirOut", 32'(dirOut), 32'(DIR_RIGHT));

        applyStimulus("badNotCmd", 32'h20DF6A94, 1'b0);
        applyStimulus("badAddr", 32'h21DE6A95, 1'b0);
        applyStimulus("badUnknown", 32'h20DF00FF, 1'b0);

        doReset();
        applyStimulus("revLeft", W_LEFT, 1'b0);
        applyStimulus("dupRight", W_RIGHT, 1'b0);
        applyStimulus("upOk", W_UP, 1'b0);
        popAndCheck("pop2");

        applyStimulus("fillUpDup", W_UP, 1'b0);
        applyStimulus("fillLeft", W_LEFT, 1'b0);
        applyStimulus("fillDown", W_DOWN, 1'b0);
        applyStimulus("fillRight", W_RIGHT, 1'b0);
        applyStimulus("fillUp", W_UP, 1'b0);
        applyStimulus("ovfLeft", W_LEFT, 1'b0);
        applyStimulus("popPushLeft", W_LEFT, 1'b1);
        for (int i = 0; i < DEPTH_A; i++) popAndCheck($sformatf("drain%0d", i));

        applyStimulus("preRstUp", W_UP, 1'b0);
        applyStimulus("preRstLeft", W_LEFT, 1'b0);
        irWord   = 32'h20DF6A94;
        irStrobe = 1'b1;
        tick();
        irStrobe = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        checkOutput("midRst.valid", 32'(dirValid), 32'd0);
        checkOutput("midRst.dirOut", 32'(dirOut), 32'(DIR_RIGHT));
        tick();
        checkOutput("midRst.frameErr1", 32'(frameErr), 32'd0);
        tick();
        reset = 1'b0;
        expQ.delete();
        modelLast = DIR_RIGHT;
        tick();
        checkOutput("postRst.frameErr", 32'(frameErr), 32'd0);
        checkOutput("postRst.valid", 32'(dirValid), 32'd0);
        applyStimulus("postRstUp", W_UP, 1'b0);
        popAndCheck("pop3");

        // Hold-off instance: edge e counts clock edges since the UP strobe.
        holdWord   = W_UP;
        holdStrobe = 1'b1;
        tick();
        e = 1;
        holdStrobe = 1'b0;
        tick();
        e++;
        checkOutput("hold.validEarly", 32'(holdValid), 32'd0);
        tick();
        e++;
        checkOutput("hold.upValid", 32'(holdValid), 32'd1);
        checkOutput("hold.upDir", 32'(holdOut), 32'(DIR_UP));
        holdReady = 1'b1;
        tick();
        e++;
        holdReady = 1'b0;
        checkOutput("hold.popped", 32'(holdValid), 32'd0);
        while (e < 52) begin
            tick();
            e++;
        end
        holdWord   = W_LEFT;
        holdStrobe = 1'b1;
        tick();
        e++;
        holdStrobe = 1'b0;
        while (e < 58) begin
            tick();
            e++;
        end
        checkOutput("hold.ignored", 32'(holdValid), 32'd0);
        while (e < 102) begin
            tick();
            e++;
        end
        holdStrobe = 1'b1;
        tick();
        e++;
        tick();
        e++;
        holdStrobe = 1'b0;
        tick();
        e++;
        checkOutput("hold.edgeTooEarly", 32'(holdValid), 32'd0);
        tick();
        e++;
        checkOutput("hold.leftValid", 32'(holdValid), 32'd1);
        checkOutput("hold.leftDir", 32'(holdOut), 32'(DIR_LEFT));
        checkOutput("hold.noErr", 32'(holdErr), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ir_dir_scheduler.md
Name: ir_dir_scheduler

Overview:
Sits between the NEC IR receiver and the snake game core. Validates each decoded 32-bit NEC frame and maps it to a direction code. Filters illegal moves: reversal, duplicate, and presses inside the hold-off window. Queues accepted moves in a small FIFO that the game consumes one per game tick via a valid/ready handshake.

Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- HOLDOFF_CYCLES, 32'd5_000_000: clk cycles after an accepted press during which new strobes are ignored; 0 disables hold-off.
- NEC_ADDR, 8'h20: required NEC address byte.
- RESET_DIR, DIR_RIGHT: initial last-accepted direction.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- ir_word  input  32  decoded NEC frame, MSB-first (addr, ~addr, cmd, ~cmd).
- ir_strobe  input  1  one-cycle pulse; ir_word is valid this cycle.
- dir_out  output  2  head-of-queue direction (dir_t).
- dir_valid  output  1  FIFO not empty.
- dir_ready  input  1  game consumes head when dir_valid & dir_ready.
- frame_err  output  1  one-cycle pulse: checksum/address/unknown-command reject.
- overflow  output  1  one-cycle pulse: legal move dropped because FIFO full.

Behaviour:
- Reset values:
  - dir_out=RESET_DIR, dir_valid=0, frame_err=0, overflow=0.
  - FIFO empty, last_dir=RESET_DIR, hold-off counter=0.
  - Reset asserted mid-operation flushes the FIFO and any in-flight frame immediately.
- Two-stage pipeline, FSM states IDLE -> CHECK -> FILTER -> IDLE:
  - IDLE: on ir_strobe with holdoff==0, latch ir_word and go to CHECK. Strobes while holdoff!=0, or while in CHECK/FILTER, are silently ignored.
  - CHECK: valid iff word[31:24]==NEC_ADDR, word[23:16]==~word[31:24], word[7:0]==~word[15:8], and cmd is one of UP 8'h6A, DOWN 8'hEA, LEFT 8'h1A, RIGHT 8'h9A.
    - Invalid: pulse frame_err next cycle, return to IDLE.
    - Valid: register the mapped dir and go to FILTER.
  - FILTER: drop silently if dir==last_dir (duplicate) or dir==opposite(last_dir) (reversal). Otherwise:
    - push if not full, or if full and a pop happens this same cycle;
    - if pushed: last_dir<=dir, holdoff<=HOLDOFF_CYCLES;
    - if full with no pop: pulse overflow; last_dir and holdoff unchanged.
    - Return to IDLE.
- Latency: strobe at cycle N -> dir_valid high at cycle N+3 if the FIFO was empty.
- last_dir tracks the last enqueued move, not the last popped one, so queued moves chain legally.
- FIFO:
  - Pointers are log2(DEPTH)+1 bits; full/empty from the MSB compare; pointers wrap naturally.
  - Pop when empty has no effect.
  - Push+pop in the same cycle keeps the count unchanged.
  - dir_out is the combinational head entry, or RESET_DIR when empty.
- Hold-off: 32-bit down-counter, decrements to 0 and saturates there.
- Scope: NEC repeat frames are never strobed by the receiver and need no handling here.

Optional Feature:
- Macro: IR_DIR_STATS_EN.
- Defined: adds outputs stat_accept, stat_err, stat_drop (16 bits each, saturating at 16'hFFFF, cleared by reset).
  - stat_accept counts pushes.
  - stat_err counts frame_err pulses.
  - stat_drop counts duplicate, reversal and overflow drops.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package snake_ir_pkg:
  - dir_t (2-bit enum: DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3);
  - NEC command constants CMD_UP, CMD_DOWN, CMD_LEFT, CMD_RIGHT;
  - function opposite(dir_t);
  - function nec_cmd_to_dir.
- Sub-module ir_dir_fifo (parameter DEPTH; push/pop/full/empty/head) instantiated once; the FSM, filter and hold-off stay in the top.

Test Plan:
- Reset, then ir_word=32'h20DF6A95 strobe with HOLDOFF_CYCLES=0 -> dir_valid at N+3, dir_out=DIR_UP; dir_ready pulse -> dir_valid=0.
- ir_word=32'h20DF6A94 (bad ~cmd), then 32'h21DE6A95 (wrong addr) -> frame_err pulse each time, FIFO stays empty.
- From RESET_DIR=RIGHT, send LEFT (32'h20DF1AE5) -> dropped, no pulse. Send RIGHT -> dropped as duplicate. Send UP -> accepted.
- DEPTH=4, dir_ready=0, send UP, LEFT, DOWN, RIGHT, UP -> 4 entries queued in order. Then send LEFT -> overflow pulse. Repeat LEFT with dir_ready=1 in the FILTER cycle -> accepted, count stays 4.
- HOLDOFF_CYCLES=100: UP accepted, LEFT strobed 50 cycles later -> ignored; LEFT strobed at 101 cycles -> accepted.
- Assert reset while in CHECK with 2 entries queued -> dir_valid=0 immediately, no frame_err; after release, UP accepted normally.
